// File: rtl/sprite_blitter.sv
// Frame renderer for a 1-bpp framebuffer: optional full-screen clear, then
// per-slot sprites from a shared image ROM with clipping, pow2 scaling and transparency.
module sprite_blitter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int SPRITES           = 4,
    parameter int SPRITE_W          = 16,
    parameter int SPRITE_H          = 16,
    parameter int IMAGES            = 4,
    parameter int MAX_SCALE_LOG2    = 2,
    localparam int XW = $clog2(HOR_ACTIVE_PIXELS) + 1,
    localparam int YW = $clog2(VER_ACTIVE_PIXELS) + 1,
    localparam int IW = (IMAGES > 1) ? $clog2(IMAGES) : 1,
    localparam int SW = (MAX_SCALE_LOG2 > 0) ? $clog2(MAX_SCALE_LOG2 + 1) : 1,
    localparam int AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS),
    localparam int RW = $clog2(IMAGES * SPRITE_W * SPRITE_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic                  clear_en,
    input  logic                  clear_color,
    input  logic [SPRITES-1:0]    spr_en,
    input  logic [SPRITES-1:0]    spr_opaque,
    input  logic [SPRITES*XW-1:0] spr_x,
    input  logic [SPRITES*YW-1:0] spr_y,
    input  logic [SPRITES*IW-1:0] spr_img,
    input  logic [SPRITES*SW-1:0] spr_scale,
    output logic [RW-1:0]         rom_addr,
    input  logic                  rom_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic                  wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int KW = (SPRITES > 1) ? $clog2(SPRITES) : 1;
    localparam int DW = ((SPRITE_W << MAX_SCALE_LOG2) > 1) ? $clog2(SPRITE_W << MAX_SCALE_LOG2) : 1;
    localparam int DH = ((SPRITE_H << MAX_SCALE_LOG2) > 1) ? $clog2(SPRITE_H << MAX_SCALE_LOG2) : 1;
    localparam int HV = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
    localparam logic signed [XW:0] H_LIM = (XW+1)'(HOR_ACTIVE_PIXELS);
    localparam logic signed [YW:0] V_LIM = (YW+1)'(VER_ACTIVE_PIXELS);

    typedef enum logic [2:0] {IDLE, CLEAR, SETUP, FETCH, PLOT, FIN} state_t;

    state_t state_reg, state_next;

    logic [KW-1:0] k_reg;
    logic [DW-1:0] dx_reg, w_last_reg;
    logic [DH-1:0] dy_reg, h_last_reg;
    logic [AW-1:0] addr_reg;
    logic          vis_reg;
    logic          clear_color_reg;

    // Descriptor snapshot, one register set per slot, captured when a frame starts
    logic                 slot_en     [SPRITES];
    logic                 slot_opaque [SPRITES];
    logic signed [XW-1:0] slot_x      [SPRITES];
    logic signed [YW-1:0] slot_y      [SPRITES];
    logic [IW-1:0]        slot_img    [SPRITES];
    logic [SW-1:0]        slot_scale  [SPRITES];

    logic load;
    assign load = ce && (state_reg == IDLE) && start;

    genvar gi;
    generate
        for (gi = 0; gi < SPRITES; gi++) begin : g_slot
            logic                 en_reg;
            logic                 opaque_reg;
            logic signed [XW-1:0] x_reg;
            logic signed [YW-1:0] y_reg;
            logic [IW-1:0]        img_reg;
            logic [SW-1:0]        scale_reg;
            logic [SW-1:0]        scale_in;

            assign scale_in = spr_scale[gi*SW +: SW];

            always_ff @(posedge clk) begin
                if (!rst && load) begin
                    en_reg     <= spr_en[gi];
                    opaque_reg <= spr_opaque[gi];
                    x_reg      <= spr_x[gi*XW +: XW];
                    y_reg      <= spr_y[gi*YW +: YW];
                    img_reg    <= spr_img[gi*IW +: IW];
                    scale_reg  <= (scale_in > SW'(MAX_SCALE_LOG2)) ? SW'(MAX_SCALE_LOG2) : scale_in;
                end
            end

            assign slot_en[gi]     = en_reg;
            assign slot_opaque[gi] = opaque_reg;
            assign slot_x[gi]      = x_reg;
            assign slot_y[gi]      = y_reg;
            assign slot_img[gi]    = img_reg;
            assign slot_scale[gi]  = scale_reg;
        end
    endgenerate

    logic signed [XW-1:0] cur_x;
    logic signed [YW-1:0] cur_y;
    logic [SW-1:0]        cur_s;
    assign cur_x = slot_x[k_reg];
    assign cur_y = slot_y[k_reg];
    assign cur_s = slot_scale[k_reg];

    logic last_col, last_row, last_sprite;
    assign last_col    = (dx_reg == w_last_reg);
    assign last_row    = (dy_reg == h_last_reg);
    assign last_sprite = (k_reg == KW'(SPRITES - 1));

    // One extra bit on each position sum so clipping compares can never wrap
    logic signed [XW:0] px_sum;
    logic signed [YW:0] py_sum;
    logic               vis;
    logic [AW-1:0]      addr_calc;
    logic [RW-1:0]      rom_calc;

    assign px_sum = $signed({cur_x[XW-1], cur_x}) + $signed({1'b0, XW'(dx_reg)});
    assign py_sum = $signed({cur_y[YW-1], cur_y}) + $signed({1'b0, YW'(dy_reg)});
    assign vis    = !px_sum[XW] && (px_sum < H_LIM) && !py_sum[YW] && (py_sum < V_LIM);
    assign addr_calc = AW'(py_sum[YW-1:0]) * AW'(HOR_ACTIVE_PIXELS) + AW'(px_sum[XW-1:0]);
    assign rom_calc  = RW'(slot_img[k_reg]) * RW'(SPRITE_W * SPRITE_H)
                     + RW'(dy_reg >> cur_s) * RW'(SPRITE_W)
                     + RW'(dx_reg >> cur_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            dx_reg          <= '0;
            dy_reg          <= '0;
            w_last_reg      <= '0;
            h_last_reg      <= '0;
            addr_reg        <= '0;
            vis_reg         <= 1'b0;
            clear_color_reg <= 1'b0;
        end else if (ce) begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        addr_reg        <= '0;
                        k_reg           <= '0;
                        clear_color_reg <= clear_color;
                    end
                end
                CLEAR: addr_reg <= addr_reg + AW'(1);
                SETUP: begin
                    if (slot_en[k_reg]) begin
                        dx_reg     <= '0;
                        dy_reg     <= '0;
                        w_last_reg <= DW'((SPRITE_W << cur_s) - 1);
                        h_last_reg <= DH'((SPRITE_H << cur_s) - 1);
                    end else if (!last_sprite) begin
                        k_reg <= k_reg + KW'(1);
                    end
                end
                FETCH: begin
                    vis_reg  <= vis;
                    addr_reg <= addr_calc;
                end
                PLOT: begin
                    if (!last_col) begin
                        dx_reg <= dx_reg + DW'(1);
                    end else begin
                        dx_reg <= '0;
                        if (!last_row)
                            dy_reg <= dy_reg + DH'(1);
                        else if (!last_sprite)
                            k_reg <= k_reg + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = 1'b0;
        rom_addr   = '0;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = clear_en ? CLEAR : SETUP;
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = addr_reg;
                wr_data = clear_color_reg;
                if (addr_reg == AW'(HV - 1))
                    state_next = SETUP;
            end
            SETUP: begin
                if (slot_en[k_reg])
                    state_next = FETCH;
                else if (last_sprite)
                    state_next = FIN;
            end
            FETCH: begin
                rom_addr   = rom_calc;
                state_next = PLOT;
            end
            PLOT: begin
                // Address stays on the bus so the ROM output holds through stalls
                rom_addr = rom_calc;
                wr_en    = vis_reg && (slot_opaque[k_reg] || rom_data);
                wr_addr  = addr_reg;
                wr_data  = rom_data;
                if (last_col && last_row)
                    state_next = last_sprite ? FIN : SETUP;
                else
                    state_next = FETCH;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: a reference renderer queues expected
// framebuffer writes; a negedge monitor pops and compares them.
module tb_sprite_blitter;

    localparam int H   = 32;
    localparam int V   = 16;
    localparam int NS  = 2;
    localparam int SPW = 4;
    localparam int SPH = 4;
    localparam int NI  = 2;
    localparam int MS  = 1;
    localparam int XW  = $clog2(H) + 1;
    localparam int YW  = $clog2(V) + 1;
    localparam int IW  = 1;
    localparam int SW  = 1;
    localparam int AW  = $clog2(H * V);
    localparam int RW  = $clog2(NI * SPW * SPH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b1;
    logic start = 1'b0;
    logic clear_en = 1'b0;
    logic clear_color = 1'b0;
    logic [NS-1:0]    spr_en = '0;
    logic [NS-1:0]    spr_opaque = '0;
    logic [NS*XW-1:0] spr_x = '0;
    logic [NS*YW-1:0] spr_y = '0;
    logic [NS*IW-1:0] spr_img = '0;
    logic [NS*SW-1:0] spr_scale = '0;
    logic [RW-1:0]    rom_addr;
    logic             rom_data = 1'b0;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             wr_data;
    logic             busy;
    logic             done;

    sprite_blitter #(
        .HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V), .SPRITES(NS),
        .SPRITE_W(SPW), .SPRITE_H(SPH), .IMAGES(NI), .MAX_SCALE_LOG2(MS)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .clear_en(clear_en), .clear_color(clear_color),
        .spr_en(spr_en), .spr_opaque(spr_opaque), .spr_x(spr_x), .spr_y(spr_y),
        .spr_img(spr_img), .spr_scale(spr_scale),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Image 0 all ones, image 1 checkerboard with (0,0) set
    function automatic int pix_model(input int img, input int r, input int c);
        if (img == 0) return 1;
        return ((r + c) % 2 == 0) ? 1 : 0;
    endfunction

    logic rom_mem [NI*SPW*SPH];
    initial begin
        for (int a = 0; a < NI*SPW*SPH; a++)
            rom_mem[a] = pix_model(a / (SPW*SPH), (a % (SPW*SPH)) / SPW, a % SPW) != 0;
    end
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int fb [H*V];

    bit t_en [NS];
    bit t_op [NS];
    int t_x [NS];
    int t_y [NS];
    int t_img [NS];
    int t_s [NS];

    bit mon_en = 1'b0;
    bit have_prev = 1'b0;
    bit prev_ce = 1'b1;
    logic [AW+RW+3:0] prev_out = '0;
    int cycle_cnt = 0;
    int done_cycle = -1;
    int wr_count = 0;
    int first_addr = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            int got;
            int e;
            cycle_cnt++;
            if (done && done_cycle < 0) done_cycle = cycle_cnt;
            if (have_prev && !prev_ce) begin
                checks++;
                if ({wr_en, wr_addr, wr_data, rom_addr, busy, done} !== prev_out) begin
                    failures++;
                    $display("FAIL ce_hold: outputs %h changed from %h while ce=0 (cycle %0d)",
                             {wr_en, wr_addr, wr_data, rom_addr, busy, done}, prev_out, cycle_cnt);
                end
            end
            if (wr_en && ce) begin
                got = int'(wr_addr) * 2 + int'(wr_data);
                if (wr_count == 0) first_addr = int'(wr_addr);
                wr_count++;
                fb[wr_addr] = int'(wr_data);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_extra: unexpected write addr=%0d data=%0d", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sb_write: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                                 got / 2, got % 2, e / 2, e % 2);
                    end
                end
            end
            prev_out  = {wr_en, wr_addr, wr_data, rom_addr, busy, done};
            prev_ce   = ce;
            have_prev = 1'b1;
        end
    end

    task automatic build_expected(input bit clr, input bit col, output int cyc);
        exp_q.delete();
        cyc = 1 + NS + 1;
        if (clr) begin
            for (int a = 0; a < H*V; a++) exp_q.push_back(a * 2 + int'(col));
            cyc += H*V;
        end
        for (int k = 0; k < NS; k++) begin
            if (t_en[k]) begin
                int w;
                int h;
                w = SPW << t_s[k];
                h = SPH << t_s[k];
                cyc += 2 * w * h;
                for (int dy = 0; dy < h; dy++) begin
                    for (int dx = 0; dx < w; dx++) begin
                        int px;
                        int py;
                        int p;
                        px = t_x[k] + dx;
                        py = t_y[k] + dy;
                        p  = pix_model(t_img[k], dy >> t_s[k], dx >> t_s[k]);
                        if (px >= 0 && px < H && py >= 0 && py < V && (t_op[k] || p != 0))
                            exp_q.push_back((py * H + px) * 2 + p);
                    end
                end
            end
        end
    endtask

    task automatic apply_desc();
        for (int k = 0; k < NS; k++) begin
            spr_en[k]              = t_en[k];
            spr_opaque[k]          = t_op[k];
            spr_x[k*XW +: XW]      = t_x[k][XW-1:0];
            spr_y[k*YW +: YW]      = t_y[k][YW-1:0];
            spr_img[k*IW +: IW]    = t_img[k][IW-1:0];
            spr_scale[k*SW +: SW]  = t_s[k][SW-1:0];
        end
    endtask

    task automatic set_sprite(input int k, input bit en, input bit op, input int x, input int y,
                              input int img, input int s);
        t_en[k] = en; t_op[k] = op; t_x[k] = x; t_y[k] = y; t_img[k] = img; t_s[k] = s;
    endtask

    task automatic run_frame(input bit clr, input bit col, input bit toggle, input bit extra_start,
                             input string name);
        int cyc;
        int i;
        apply_desc();
        clear_en = clr;
        clear_color = col;
        build_expected(clr, col, cyc);
        @(posedge clk); #1;
        cycle_cnt = 0; done_cycle = -1; wr_count = 0; first_addr = -1; have_prev = 1'b0;
        mon_en = 1'b1;
        start = 1'b1;
        ce = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (toggle) ce = 1'b0;
        // Inputs change after acceptance; the frame must use the snapshot
        spr_en = ~spr_en; spr_opaque = ~spr_opaque; spr_x = ~spr_x; spr_y = ~spr_y;
        spr_img = ~spr_img; clear_color = ~clear_color; clear_en = ~clear_en;
        i = 0;
        while (done_cycle < 0 && i < 5000) begin
            @(posedge clk); #1;
            if (toggle) ce = ~ce;
            start = extra_start && (i == 40);
            i++;
        end
        start = 1'b0;
        checks++;
        if (done_cycle < 0) begin
            failures++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, i);
        end
        ce = 1'b1;
        if (toggle) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_done: busy=%b done=%b, expected 0 0", name, busy, done);
        end
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d expected writes never seen", name, exp_q.size());
        end
        checks++;
        if (done_cycle !== (toggle ? 2 * (cyc - 1) : cyc)) begin
            failures++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_cycle,
                     toggle ? 2 * (cyc - 1) : cyc);
        end
        $display("frame %s: writes=%0d first_addr=%0d done_cycle=%0d", name, wr_count, first_addr, done_cycle);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, rom_addr, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got wr_en=%b wr_addr=%0d wr_data=%b rom_addr=%0d busy=%b done=%b, expected all 0",
                     wr_en, wr_addr, wr_data, rom_addr, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b wr_en=%b, expected 0 0", busy, wr_en);
        end
    endtask

    task automatic test_clear();
        set_sprite(0, 0, 0, 0, 0, 0, 0);
        set_sprite(1, 0, 0, 0, 0, 0, 0);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, "clear");
        checks++;
        if (wr_count !== 512) begin
            failures++;
            $display("FAIL clear_count: got %0d writes, expected 512", wr_count);
        end
    endtask

    task automatic test_transparent();
        set_sprite(0, 1, 0, 3, 2, 1, 0);
        set_sprite(1, 0, 0, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, "transparent");
        checks++;
        if (wr_count !== 8 || first_addr !== 67) begin
            failures++;
            $display("FAIL transparent_writes: got count=%0d first=%0d, expected 8 and 67", wr_count, first_addr);
        end
    endtask

    task automatic test_clip_scale();
        set_sprite(0, 1, 1, -2, 14, 0, 1);
        set_sprite(1, 0, 0, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, "clip_scale");
        checks++;
        if (wr_count !== 12 || first_addr !== 448) begin
            failures++;
            $display("FAIL clip_writes: got count=%0d first=%0d, expected 12 and 448", wr_count, first_addr);
        end
    endtask

    task automatic test_overlap();
        set_sprite(0, 1, 0, 0, 0, 0, 0);
        set_sprite(1, 1, 1, 0, 0, 1, 0);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, "overlap");
        checks++;
        if (wr_count !== 544) begin
            failures++;
            $display("FAIL overlap_count: got %0d writes, expected 544", wr_count);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (fb[r*H + c] !== (((r + c) % 2 == 0) ? 1 : 0)) begin
                    failures++;
                    $display("FAIL overlap_fb: pixel (%0d,%0d) got %0d expected %0d", c, r,
                             fb[r*H + c], ((r + c) % 2 == 0) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_ce_toggle();
        set_sprite(0, 1, 0, 3, 2, 1, 0);
        set_sprite(1, 0, 0, 0, 0, 0, 0);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, "ce_toggle");
        checks++;
        if (wr_count !== 8 || first_addr !== 67) begin
            failures++;
            $display("FAIL ce_toggle_writes: got count=%0d first=%0d, expected 8 and 67", wr_count, first_addr);
        end
    endtask

    task automatic test_midframe_reset();
        bit hit;
        set_sprite(0, 0, 0, 0, 0, 0, 0);
        set_sprite(1, 0, 0, 0, 0, 0, 0);
        apply_desc();
        clear_en = 1'b1;
        clear_color = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == AW'(100)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midreset_reach: clear never reached address 100");
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: wr_en=%b busy=%b done=%b, expected 0 0 0", wr_en, busy, done);
        end
        run_frame(1'b1, 1'b1, 1'b0, 1'b1, "restart");
        checks++;
        if (wr_count !== 512 || first_addr !== 0) begin
            failures++;
            $display("FAIL restart_writes: got count=%0d first=%0d, expected 512 and 0", wr_count, first_addr);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_transparent();
        test_clip_scale();
        test_overlap();
        test_ce_toggle();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
